// File: rtl/mem_word_master_pkg.sv
// Shared types and defaults for the word master and its byte gather.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, default geometry, lane-index width helper.
package mem_word_master_pkg;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_RAM_ADDR_BITS = 8;
   localparam int DEF_BYTES         = 4;

   // Each state names the action taken at the edge that leaves it.
   // IDLE loads byte 0 onto the RAM bus. ACCESS loads the following bytes.
   // DRAIN drops mem_en while the last byte is captured. RESP raises rsp_valid.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // A lane index needs at least one bit, even when a word is a single byte.
   function automatic int idx_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/mem_byte_gather.sv
// Assembles a word from single RAM bytes, one lane per capture.
// Latency: a byte presented with cap_en appears in word after one clk edge.
// Backpressure: none; it captures every cycle that cap_en is high.
// Ports: clk, reset_n (sync, active-low); cap_en/cap_lane/cap_dat select and load one lane;
//        word is the assembled register. Only the addressed lane changes.
module mem_byte_gather #(
   parameter int WIDTH = 8,
   parameter int BYTES = 4,
   parameter int IDX_W = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cap_en,
   input  logic [IDX_W-1:0]       cap_lane,
   input  logic [WIDTH-1:0]       cap_dat,
   output logic [WIDTH*BYTES-1:0] word
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word <= '0;
      end else if (cap_en) begin
         word[WIDTH*cap_lane +: WIDTH] <= cap_dat;
      end
   end

endmodule

// File: rtl/mem_word_master.sv
// Word-level initiator for the byte-wide, negedge-clocked RAM port: one request -> BYTES byte accesses -> one response.
// Latency: accept at edge E0, mem_en high in cycles 1..BYTES, rsp_valid pulse in cycle BYTES+2.
// Backpressure: req_ready is high only in IDLE; one word per BYTES+2 cycles at best.
// Ports: clk, reset_n (sync, active-low); req_valid/req_ready/req_write/req_adr/req_wdata request side;
//        rsp_valid/rsp_rdata response side; mem_en/mem_memwrite/mem_adr/mem_writedata drive the RAM,
//        and mem_memdata returns from it.
module mem_word_master
   import mem_word_master_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
   parameter int BYTES         = DEF_BYTES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [RAM_ADDR_BITS-1:0] req_adr,
   input  logic [WIDTH*BYTES-1:0]   req_wdata,
   output logic                     rsp_valid,
   output logic [WIDTH*BYTES-1:0]   rsp_rdata,
   output logic                     mem_en,
   output logic                     mem_memwrite,
   output logic [RAM_ADDR_BITS-1:0] mem_adr,
   output logic [WIDTH-1:0]         mem_writedata,
   input  logic [WIDTH-1:0]         mem_memdata
);

   localparam int               IDX_W    = idx_width(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;       // lane currently on the RAM bus
   logic                     wr_q, wr_d;
   logic [RAM_ADDR_BITS-1:0] base_q, base_d;
   logic [WIDTH*BYTES-1:0]   wdata_q, wdata_d;
   logic                     en_d, we_d, rsp_vld_d;
   logic [RAM_ADDR_BITS-1:0] adr_d;
   logic [WIDTH-1:0]         wd_d;

   assign req_ready = (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         wr_q          <= 1'b0;
         base_q        <= '0;
         wdata_q       <= '0;
         mem_en        <= 1'b0;
         mem_memwrite  <= 1'b0;
         mem_adr       <= '0;
         mem_writedata <= '0;
         rsp_valid     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wr_q          <= wr_d;
         base_q        <= base_d;
         wdata_q       <= wdata_d;
         mem_en        <= en_d;
         mem_memwrite  <= we_d;
         mem_adr       <= adr_d;
         mem_writedata <= wd_d;
         rsp_valid     <= rsp_vld_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      en_d      = 1'b0;
      we_d      = 1'b0;
      adr_d     = mem_adr;
      wd_d      = mem_writedata;
      rsp_vld_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               // Byte 0 goes out straight from the request so mem_en rises in cycle 1.
               wr_d    = req_write;
               base_d  = req_adr;
               wdata_d = req_wdata;
               idx_d   = '0;
               en_d    = 1'b1;
               we_d    = req_write;
               adr_d   = req_adr;
               wd_d    = req_wdata[WIDTH-1:0];
               state_d = (BYTES == 1) ? ST_DRAIN : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            idx_d = idx_q + IDX_W'(1);
            en_d  = 1'b1;
            we_d  = wr_q;
            // Address arithmetic wraps silently at the top of the RAM.
            adr_d = base_q + RAM_ADDR_BITS'(idx_d);
            wd_d  = wdata_q[WIDTH*idx_d +: WIDTH];
            if (idx_d == LAST_IDX) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_vld_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The RAM answers on the negedge, so the byte on the bus this cycle is
   // valid at the closing posedge; capture overlaps issue of the next byte.
   mem_byte_gather #(
      .WIDTH (WIDTH),
      .BYTES (BYTES),
      .IDX_W (IDX_W)
   ) u_gather (
      .clk      (clk),
      .reset_n  (reset_n),
      .cap_en   (mem_en),
      .cap_lane (idx_q),
      .cap_dat  (mem_memdata),
      .word     (rsp_rdata)
   );

endmodule

// File: tb/tb_mem_word_master.sv
// Bench for mem_word_master driving a negedge-clocked, read-before-write byte RAM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_word_master;

   localparam int BYTES = 4;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_adr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic        mem_memwrite;
   logic [7:0]  mem_adr;
   logic [7:0]  mem_writedata;
   logic [7:0]  mem_memdata;

   logic [7:0]  ram    [256];
   logic [7:0]  shadow [256];
   logic [31:0] sb_q   [$];

   int checks;
   int errors;

   mem_word_master #(
      .WIDTH         (8),
      .RAM_ADDR_BITS (8),
      .BYTES         (BYTES)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_adr       (req_adr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .mem_en        (mem_en),
      .mem_memwrite  (mem_memwrite),
      .mem_adr       (mem_adr),
      .mem_writedata (mem_writedata),
      .mem_memdata   (mem_memdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM: acts on negedge, returns old contents on a write.
   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_memwrite === 1'b1) ram[mem_adr] <= mem_writedata;
         mem_memdata <= ram[mem_adr];
      end
   end

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 37 + 5) & 255);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete request with cycle-by-cycle bus checks; returns the observed rdata.
   task automatic do_req(input logic wr, input logic [7:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic [7:0]  a;
      logic        exp_en;
      logic [7:0]  exp_adr;
      logic [7:0]  exp_wd;
      rd     = 'x;
      exp_rd = '0;
      for (int b = 0; b < BYTES; b++) begin
         a = adr + 8'(b);
         exp_rd[8*b +: 8] = shadow[a];
         if (wr) shadow[a] = wd[8*b +: 8];
      end
      sb_q.push_back(exp_rd);
      req_valid = 1'b1;
      req_write = wr;
      req_adr   = adr;
      req_wdata = wd;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready: got %b want 1", req_ready);
      end
      step();
      // Scrambled inputs after the accept edge must be ignored.
      req_valid = 1'b0;
      req_write = ~wr;
      req_adr   = ~adr;
      req_wdata = ~wd;
      for (int k = 1; k <= BYTES + 2; k++) begin
         exp_en = (k <= BYTES);
         checks++;
         if (mem_en !== exp_en || mem_memwrite !== (exp_en & wr)) begin
            errors++;
            $display("FAIL bus_ctrl cyc%0d: en=%b we=%b want en=%b we=%b", k, mem_en, mem_memwrite,
                     exp_en, exp_en & wr);
         end
         if (exp_en) begin
            exp_adr = adr + 8'(k - 1);
            exp_wd  = wd[8*(k-1) +: 8];
            checks++;
            if (mem_adr !== exp_adr || mem_writedata !== exp_wd) begin
               errors++;
               $display("FAIL bus_byte cyc%0d: adr=%h wd=%h want adr=%h wd=%h", k, mem_adr,
                        mem_writedata, exp_adr, exp_wd);
            end
         end
         checks++;
         if (rsp_valid !== (k == BYTES + 2)) begin
            errors++;
            $display("FAIL rsp_valid cyc%0d: got %b want %b", k, rsp_valid, k == BYTES + 2);
         end
         checks++;
         if (req_ready !== (k == BYTES + 2)) begin
            errors++;
            $display("FAIL req_ready cyc%0d: got %b want %b", k, req_ready, k == BYTES + 2);
         end
         if (k == BYTES + 2 && rsp_valid === 1'b1 && sb_q.size() > 0) begin
            rd     = rsp_rdata;
            exp_rd = sb_q.pop_front();
            checks++;
            if (rsp_rdata !== exp_rd) begin
               errors++;
               $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, exp_rd);
            end
         end
         step();
      end
      if (sb_q.size() != 0) begin
         sb_q.delete();
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_pulse_width: rsp_valid=%b after RESP, want 0", rsp_valid);
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_adr   = 8'h80;
      req_wdata = 32'h01020304;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (mem_en !== 1'b0 || mem_memwrite !== 1'b0 || mem_adr !== 8'h00 ||
             mem_writedata !== 8'h00 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
             req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals cyc%0d: en=%b we=%b adr=%h wd=%h rv=%b rd=%h rdy=%b want 0,0,00,00,0,0,1",
                     c, mem_en, mem_memwrite, mem_adr, mem_writedata, rsp_valid, rsp_rdata, req_ready);
         end
      end
      req_valid = 1'b0;
      reset_n   = 1'b1;
      step();
      checks++;
      if (mem_en !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_accept: en=%b rdy=%b want 0,1", mem_en, req_ready);
      end
      checks++;
      if (ram[8'h80] !== init_val(8'h80)) begin
         errors++;
         $display("FAIL reset_ram_untouched: got %h want %h", ram[8'h80], init_val(8'h80));
      end
   endtask

   task automatic test_write_basic();
      logic [31:0] rd;
      logic [31:0] w;
      w = 32'hDEADBEEF;
      do_req(1'b1, 8'h10, w, rd);
      for (int b = 0; b < BYTES; b++) begin
         checks++;
         if (ram[8'h10 + b] !== w[8*b +: 8]) begin
            errors++;
            $display("FAIL write_ram[%h]: got %h want %h", 8'h10 + b, ram[8'h10 + b], w[8*b +: 8]);
         end
      end
   endtask

   task automatic test_read_basic();
      logic [31:0] rd;
      do_req(1'b0, 8'h10, 32'h0BADF00D, rd);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_word: got %h want deadbeef", rd);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      logic [7:0]  wa [4];
      logic [31:0] w;
      wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      w  = 32'h44332211;
      do_req(1'b1, 8'hFE, w, rd);
      for (int b = 0; b < BYTES; b++) begin
         checks++;
         if (ram[wa[b]] !== w[8*b +: 8]) begin
            errors++;
            $display("FAIL wrap_ram[%h]: got %h want %h", wa[b], ram[wa[b]], w[8*b +: 8]);
         end
      end
      do_req(1'b0, 8'hFE, 32'h0, rd);
      checks++;
      if (rd !== 32'h44332211) begin
         errors++;
         $display("FAIL wrap_read: got %h want 44332211", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  adrs [3];
      logic [31:0] exp_rd;
      logic [7:0]  a;
      int          n_acc;
      int          n_rsp;
      int          last_rsp;
      int          extra;
      adrs     = '{8'h10, 8'hFE, 8'h40};
      n_acc    = 0;
      n_rsp    = 0;
      last_rsp = -1;
      extra    = 0;
      req_write = 1'b0;
      req_wdata = 32'h0;
      for (int t = 0; t < 40 && n_rsp < 3; t++) begin
         req_valid = (n_acc < 3);
         if (n_acc < 3) req_adr = adrs[n_acc];
         if (rsp_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious_rsp: rdata=%h with empty scoreboard", rsp_rdata);
            end else begin
               exp_rd = sb_q.pop_front();
               if (rsp_rdata !== exp_rd) begin
                  errors++;
                  $display("FAIL b2b_rdata #%0d: got %h want %h", n_rsp, rsp_rdata, exp_rd);
               end
            end
            if (last_rsp >= 0) begin
               checks++;
               if (t - last_rsp != BYTES + 2) begin
                  errors++;
                  $display("FAIL b2b_spacing: got %0d want %0d", t - last_rsp, BYTES + 2);
               end
            end
            last_rsp = t;
            n_rsp++;
         end
         if (req_valid && req_ready === 1'b1) begin
            exp_rd = '0;
            for (int b = 0; b < BYTES; b++) begin
               a = adrs[n_acc] + 8'(b);
               exp_rd[8*b +: 8] = shadow[a];
            end
            sb_q.push_back(exp_rd);
            n_acc++;
         end
         step();
      end
      req_valid = 1'b0;
      checks++;
      if (n_rsp != 3 || n_acc != 3) begin
         errors++;
         $display("FAIL b2b_count: accepted=%0d responses=%0d want 3,3", n_acc, n_rsp);
      end
      for (int t = 0; t < 10; t++) begin
         if (rsp_valid === 1'b1) extra++;
         step();
      end
      checks++;
      if (extra != 0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_leftover: extra_rsp=%0d pending=%0d want 0,0", extra, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_op();
      int n_rsp;
      int n_en;
      n_rsp = 0;
      n_en  = 0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_adr   = 8'h20;
      req_wdata = 32'hCAFEF00D;
      step();
      req_valid = 1'b0;
      step();
      checks++;
      if (mem_en !== 1'b1 || mem_adr !== 8'h21) begin
         errors++;
         $display("FAIL midrst_byte1: en=%b adr=%h want 1,21", mem_en, mem_adr);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++;
      if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_vals: en=%b rv=%b rdy=%b rd=%h want 0,0,1,0", mem_en, rsp_valid,
                  req_ready, rsp_rdata);
      end
      for (int t = 0; t < 10; t++) begin
         if (rsp_valid === 1'b1) n_rsp++;
         if (mem_en === 1'b1) n_en++;
         step();
      end
      checks++;
      if (n_rsp != 0 || n_en != 0) begin
         errors++;
         $display("FAIL midrst_quiet: rsp=%0d en=%0d want 0,0", n_rsp, n_en);
      end
      checks++;
      if (ram[8'h20] !== 8'h0D || ram[8'h21] !== 8'hF0) begin
         errors++;
         $display("FAIL midrst_written: got %h %h want 0d f0", ram[8'h20], ram[8'h21]);
      end
      checks++;
      if (ram[8'h22] !== init_val(8'h22) || ram[8'h23] !== init_val(8'h23)) begin
         errors++;
         $display("FAIL midrst_untouched: got %h %h want %h %h", ram[8'h22], ram[8'h23],
                  init_val(8'h22), init_val(8'h23));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_adr   = 8'h00;
      req_wdata = 32'h0;
      for (int i = 0; i < 256; i++) begin
         ram[i]    = init_val(i);
         shadow[i] = init_val(i);
      end
      test_reset();
      test_write_basic();
      test_read_basic();
      test_wrap();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
